// File: rtl/demo_txn_sequencer.sv
// Write-write-read stimulus sequencer for a demo bus master port, with iteration count and bus timeout.
// Optional macro SEQ_RETRY_EN: re-issue a transaction once after its first completion timeout.
module demo_txn_sequencer #(
    parameter int ITERATIONS = 10,
    parameter int ITER_W     = 8,
    parameter int START_LEN  = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic              ready_i,
    input  logic              sready_i,
    output logic              start_o,
    output logic              mode_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic [1:0]        step_o,
    output logic [2:0]        state_o
);

    // Handshake: start_o is held high for START_LEN cycles per transaction, and the
    // transaction is complete on the first cycle where ready_i and sready_i are both high.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RDY  = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    localparam int CNT_MAX    = (START_LEN > GAP_CYCLES) ? START_LEN : GAP_CYCLES;
    localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int TMR_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int GAP_LAST_I = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LAST_I);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]      ITER_TGT   = ITERATIONS;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [1:0]        step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [ITER_W-1:0] iter_inc;
`ifdef SEQ_RETRY_EN
    logic              retry_q, retry_d;
`endif

    // Saturate rather than wrap when ITERATIONS exceeds the counter range.
    assign iter_inc = (iter_q == {ITER_W{1'b1}}) ? iter_q : iter_q + 1'b1;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        iter_d  = iter_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
`ifdef SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE, S_ERR: begin
                if (go_i) begin
                    iter_d  = '0;
                    step_d  = 2'd0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    tmr_d   = '0;
`ifdef SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                    if (ITERATIONS == 0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_RDY;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (ready_i) begin
                    state_d = S_ISSUE;
                    start_d = 1'b1;
                    mode_d  = (step_q < 2'd2);
                    cnt_d   = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (cnt_q == START_LAST) begin
                    state_d = S_WAIT_DONE;
                    start_d = 1'b0;
                    tmr_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (ready_i && sready_i) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
`ifdef SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                end else if (tmr_q == TMR_LAST) begin
`ifdef SEQ_RETRY_EN
                    if (!retry_q) begin
                        // Step and mode are untouched, so the re-issue repeats the same transaction.
                        state_d = S_WAIT_RDY;
                        retry_d = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    tmr_d = '0;
                    if (step_q != 2'd2) begin
                        step_d  = step_q + 1'b1;
                        state_d = S_WAIT_RDY;
                    end else begin
                        step_d = 2'd0;
                        iter_d = iter_inc;
                        if (32'(iter_inc) == ITER_TGT) begin
                            state_d = S_FINISH;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_WAIT_RDY;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            iter_q  <= '0;
            step_q  <= 2'd0;
            cnt_q   <= '0;
            tmr_q   <= '0;
`ifdef SEQ_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            iter_q  <= iter_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
`ifdef SEQ_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign start_o    = start_q;
    assign mode_o     = mode_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign iter_cnt_o = iter_q;
    assign step_o     = step_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_demo_txn_sequencer.sv
// Bench for demo_txn_sequencer: a start-pulse monitor pops expected {iter, step, mode} items from a queue.
module tb_demo_txn_sequencer;

    localparam int P_ITER  = 2;
    localparam int P_START = 2;
    localparam int P_GAP   = 2;
    localparam int P_TMO   = 15;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;
    localparam logic [2:0] ST_ERR       = 3'd6;

    logic       clk, rst, go, go0, ready, sready;
    logic       start_o, mode_o, busy_o, done_o, error_o;
    logic [7:0] iter_cnt_o;
    logic [1:0] step_o;
    logic [2:0] state_o;
    logic       start0, mode0, busy0, done0, error0;
    logic [7:0] iter0;
    logic [1:0] step0;
    logic [2:0] state0;

    logic [10:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          starts_seen = 0;
    bit          slave_en = 1'b0;
    int          slave_delay = 3;

    demo_txn_sequencer #(.ITERATIONS(P_ITER), .ITER_W(8), .START_LEN(P_START),
                         .GAP_CYCLES(P_GAP), .TIMEOUT(P_TMO)) dut (
        .clk(clk), .rst(rst), .go_i(go), .ready_i(ready), .sready_i(sready),
        .start_o(start_o), .mode_o(mode_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .iter_cnt_o(iter_cnt_o), .step_o(step_o), .state_o(state_o)
    );

    demo_txn_sequencer #(.ITERATIONS(0), .ITER_W(8), .START_LEN(P_START),
                         .GAP_CYCLES(P_GAP), .TIMEOUT(P_TMO)) dut0 (
        .clk(clk), .rst(rst), .go_i(go0), .ready_i(ready), .sready_i(sready),
        .start_o(start0), .mode_o(mode0), .busy_o(busy0), .done_o(done0),
        .error_o(error0), .iter_cnt_o(iter0), .step_o(step0), .state_o(state0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic monitor();
        logic        prev;
        int          len;
        logic [10:0] got, exp_item;
        prev = 1'b0;
        len  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                len  = 0;
            end else begin
                if (start_o === 1'b1 && !prev) begin
                    starts_seen++;
                    got = {iter_cnt_o, step_o, mode_o};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL start_unexpected got=%h exp=none", got);
                    end else begin
                        exp_item = exp_q.pop_front();
                        if (got !== exp_item) begin
                            bad++;
                            $display("FAIL start_item got=%h exp=%h", got, exp_item);
                        end
                    end
                    len = 1;
                end else if (start_o === 1'b1) begin
                    len++;
                end else if (prev) begin
                    total++;
                    if (len !== P_START) begin
                        bad++;
                        $display("FAIL start_len got=%0d exp=%0d", len, P_START);
                    end
                end
                prev = (start_o === 1'b1);
            end
        end
    endtask

    task automatic slave_model();
        int scnt;
        scnt = 1000;
        forever begin
            @(negedge clk);
            if (start_o === 1'b1) scnt = 0;
            else if (scnt < 1000) scnt++;
            if (slave_en) sready = (start_o !== 1'b1) && (scnt > slave_delay);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        go  = 1'b0;
        go0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_run();
        for (int it = 0; it < P_ITER; it++)
            for (int s = 0; s < 3; s++)
                exp_q.push_back({8'(it), 2'(s), (s < 2) ? 1'b1 : 1'b0});
    endtask

    // Full run from go to done, optionally hammering go while busy.
    task automatic run_full(input string tag, input bit spam);
        logic [7:0] last_iter;
        int         dones;
        push_run();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        total++;
        if (busy_o !== 1'b1 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_start busy/err got=%b%b exp=10", tag, busy_o, error_o);
        end
        total++;
        if (iter_cnt_o !== 8'd0 || step_o !== 2'd0) begin
            bad++;
            $display("FAIL %s_clear iter/step got=%0d/%0d exp=0/0", tag, iter_cnt_o, step_o);
        end
        last_iter = 8'd0;
        dones = 0;
        for (int k = 0; k < 400 && dones == 0; k++) begin
            if (spam) go = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (iter_cnt_o !== last_iter) begin
                total++;
                if (iter_cnt_o !== last_iter + 8'd1) begin
                    bad++;
                    $display("FAIL %s_iter_step got=%0d exp=%0d", tag, iter_cnt_o, last_iter + 8'd1);
                end
                last_iter = iter_cnt_o;
            end
            if (done_o === 1'b1) begin
                dones++;
                go = 1'b0;
                total++;
                if (busy_o !== 1'b0 || iter_cnt_o !== 8'(P_ITER)) begin
                    bad++;
                    $display("FAIL %s_done_state busy=%b iter=%0d exp busy=0 iter=%0d", tag, busy_o, iter_cnt_o, P_ITER);
                end
            end
        end
        go = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s_done_seen got=%0d exp=1", tag, dones);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        total++;
        if (dones != 1 || iter_cnt_o !== 8'(P_ITER) || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_after_done dones=%0d iter=%0d busy=%b exp 1/%0d/0", tag, dones, iter_cnt_o, busy_o, P_ITER);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_starts got=%0d exp=0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({start_o, mode_o, busy_o, done_o, error_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {start_o, mode_o, busy_o, done_o, error_o});
        end
        total++;
        if (iter_cnt_o !== 8'd0 || step_o !== 2'd0 || state_o !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_regs iter=%0d step=%0d state=%0d exp 0/0/0", iter_cnt_o, step_o, state_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        ready = 1'b1;
        slave_en = 1'b1;
        slave_delay = 3;
        starts_seen = 0;
        run_full("basic", 1'b0);
        total++;
        if (starts_seen != 3 * P_ITER) begin
            bad++;
            $display("FAIL basic_start_count got=%0d exp=%0d", starts_seen, 3 * P_ITER);
        end
    endtask

    task automatic test_ready_timeout();
        int starts;
        do_reset();
        ready = 1'b0;
        slave_en = 1'b1;
        starts = 0;
        go = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            go = 1'b0;
            if (start_o === 1'b1) starts++;
            if (k == P_TMO) begin
                total++;
                if (error_o !== 1'b0) begin
                    bad++;
                    $display("FAIL rdy_tmo_early got=%b exp=0", error_o);
                end
            end
            if (k == P_TMO + 1) begin
                total++;
                if (error_o !== 1'b1 || busy_o !== 1'b0 || state_o !== ST_ERR) begin
                    bad++;
                    $display("FAIL rdy_tmo_err err=%b busy=%b state=%0d exp 1/0/%0d", error_o, busy_o, state_o, ST_ERR);
                end
            end
        end
        total++;
        if (starts != 0 || error_o !== 1'b1) begin
            bad++;
            $display("FAIL rdy_tmo_hold starts=%0d err=%b exp 0/1", starts, error_o);
        end
        ready = 1'b1;
        run_full("restart", 1'b0);
    endtask

    task automatic test_done_timeout();
        bit seen;
        int j, exp_j;
        do_reset();
        ready = 1'b1;
        slave_en = 1'b0;
        sready = 1'b0;
        exp_q.push_back({8'd0, 2'd0, 1'b1});
`ifdef SEQ_RETRY_EN
        exp_q.push_back({8'd0, 2'd0, 1'b1});
        exp_j = 2 * P_TMO + 1 + P_START;
`else
        exp_j = P_TMO;
`endif
        go = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            go = 1'b0;
            if (start_o === 1'b1) seen = 1'b1;
            else if (seen) break;
        end
        j = 0;
        while (error_o !== 1'b1 && j < 100) begin
            @(negedge clk);
            j++;
        end
        total++;
        if (j != exp_j) begin
            bad++;
            $display("FAIL done_tmo_cycles got=%0d exp=%0d", j, exp_j);
        end
        total++;
        if (mode_o !== 1'b1 || step_o !== 2'd0 || busy_o !== 1'b0 || start_o !== 1'b0) begin
            bad++;
            $display("FAIL done_tmo_hold mode=%b step=%0d busy=%b start=%b exp 1/0/0/0", mode_o, step_o, busy_o, start_o);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL done_tmo_reissue left=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_gap_timing();
        bit seen;
        int k;
        do_reset();
        ready = 1'b1;
        slave_en = 1'b0;
        sready = 1'b0;
        exp_q.push_back({8'd0, 2'd0, 1'b1});
        exp_q.push_back({8'd0, 2'd1, 1'b1});
        go = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            go = 1'b0;
            if (start_o === 1'b1) seen = 1'b1;
            else if (seen) break;
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++;
            if (state_o !== ST_WAIT_DONE) begin
                bad++;
                $display("FAIL gap_ready_only got=%0d exp=%0d", state_o, ST_WAIT_DONE);
            end
        end
        ready = 1'b0;
        sready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (state_o !== ST_WAIT_DONE) begin
            bad++;
            $display("FAIL gap_sready_only got=%0d exp=%0d", state_o, ST_WAIT_DONE);
        end
        ready = 1'b1;
        @(negedge clk);
        total++;
        if (state_o !== ST_GAP) begin
            bad++;
            $display("FAIL gap_entry got=%0d exp=%0d", state_o, ST_GAP);
        end
        sready = 1'b0;
        k = 1;
        while (start_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k != P_GAP + 2) begin
            bad++;
            $display("FAIL gap_to_start got=%0d exp=%0d", k, P_GAP + 2);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || start_o !== 1'b0) begin
            bad++;
            $display("FAIL gap_items left=%0d start=%b exp 0/0", exp_q.size(), start_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b1;
        slave_en = 1'b1;
        slave_delay = 3;
        exp_q.push_back({8'd0, 2'd0, 1'b1});
        go = 1'b1;
        for (int n = 0; n < 20 && start_o !== 1'b1; n++) begin
            @(negedge clk);
            go = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (start_o !== 1'b0 || busy_o !== 1'b0 || iter_cnt_o !== 8'd0 || state_o !== ST_IDLE) begin
            bad++;
            $display("FAIL rst_mid start=%b busy=%b iter=%0d state=%0d exp 0/0/0/0", start_o, busy_o, iter_cnt_o, state_o);
        end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_full("after_rst", 1'b0);
    endtask

    task automatic test_go_while_busy();
        do_reset();
        ready = 1'b1;
        slave_en = 1'b1;
        slave_delay = 3;
        run_full("go_spam", 1'b1);
    endtask

    task automatic test_iter_zero();
        int starts;
        do_reset();
        starts = 0;
        go0 = 1'b1;
        @(negedge clk);
        go0 = 1'b0;
        if (start0 === 1'b1) starts++;
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL zero_done got done=%b busy=%b exp 1/0", done0, busy0);
        end
        @(negedge clk);
        total++;
        if (done0 !== 1'b0) begin
            bad++;
            $display("FAIL zero_pulse_len got=%b exp=0", done0);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (start0 === 1'b1) starts++;
        end
        total++;
        if (starts != 0 || state0 !== ST_IDLE || {mode0, error0, iter0, step0} !== 12'd0) begin
            bad++;
            $display("FAIL zero_quiet starts=%0d state=%0d exp 0/%0d", starts, state0, ST_IDLE);
        end
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        go0 = 1'b0;
        ready = 1'b0;
        sready = 1'b0;
        fork
            monitor();
            slave_model();
        join_none
        test_reset();
        test_basic();
        test_ready_timeout();
        test_done_timeout();
        test_gap_timing();
        test_reset_mid();
        test_go_while_busy();
        test_iter_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
